// File: rtl/img_seq_pkg.sv
// Shared pass encoding and geometry constants for the image pass sequencer.
package img_seq_pkg;

    typedef enum logic [1:0] {
        PASS_IDLE = 2'd0,
        PASS_GRAY = 2'd1,
        PASS_CMP  = 2'd2,
        PASS_ENC  = 2'd3
    } pass_e;

    localparam int IMG_SIDE       = 64;
    localparam int BLK_SIDE       = 4;
    localparam int CMP_SWEEPS_DEF = 4;
    localparam int ENC_SWEEPS_DEF = 2;

endpackage

// File: rtl/blk_scan_counter.sv
// Block-base + in-block offset + sweep counter; raster mode treats the whole image as one block.
module blk_scan_counter #(
    parameter int IMG_LOG2 = 6,
    parameter int BLK_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                advance,
    input  logic                blk_mode,
    input  logic [1:0]          last_sweep,
    output logic [IMG_LOG2-1:0] row,
    output logic [IMG_LOG2-1:0] col,
    output logic [1:0]          sweep,
    output logic                at_first,
    output logic                at_blk_last,
    output logic                pass_end
);

    localparam logic [IMG_LOG2-1:0] BLK_STEP = IMG_LOG2'(1) << BLK_LOG2;
    localparam logic [IMG_LOG2-1:0] BLK_MASK = BLK_STEP - IMG_LOG2'(1);

    logic [IMG_LOG2-1:0] base_r, base_c, off_r, off_c;
    logic [IMG_LOG2-1:0] off_max, base_max;
    logic                off_c_end, off_r_end, sweep_end, base_c_end, base_r_end;

    // In raster mode the base pinned at 0 always reads as "at its end", so the
    // same carry chain yields the end-of-image condition.
    assign off_max    = blk_mode ? BLK_MASK : '1;
    assign base_max   = blk_mode ? ~BLK_MASK : '0;
    assign off_c_end  = (off_c == off_max);
    assign off_r_end  = (off_r == off_max);
    assign sweep_end  = (sweep == last_sweep);
    assign base_c_end = (base_c == base_max);
    assign base_r_end = (base_r == base_max);

    assign row         = base_r | off_r;
    assign col         = base_c | off_c;
    assign at_first    = (off_r == '0) && (off_c == '0);
    assign at_blk_last = off_c_end && off_r_end && sweep_end;
    assign pass_end    = at_blk_last && base_c_end && base_r_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            base_r <= '0;
            base_c <= '0;
            off_r  <= '0;
            off_c  <= '0;
            sweep  <= '0;
        end else if (advance) begin
            if (!off_c_end) begin
                off_c <= off_c + IMG_LOG2'(1);
            end else begin
                off_c <= '0;
                if (!off_r_end) begin
                    off_r <= off_r + IMG_LOG2'(1);
                end else begin
                    off_r <= '0;
                    if (!sweep_end) begin
                        sweep <= sweep + 2'd1;
                    end else begin
                        sweep <= '0;
                        if (!base_c_end) begin
                            base_c <= base_c + BLK_STEP;
                        end else begin
                            base_c <= '0;
                            base_r <= base_r_end ? '0 : base_r + BLK_STEP;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/img_pass_sequencer.sv
// GRAY -> COMPRESS -> ENCODE coordinate scheduler with sticky per-pass done flags.
// Optional macro SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module img_pass_sequencer
    import img_seq_pkg::*;
#(
    parameter int IMG_LOG2   = 6,
    parameter int BLK_LOG2   = 2,
    parameter int CMP_SWEEPS = CMP_SWEEPS_DEF,
    parameter int ENC_SWEEPS = ENC_SWEEPS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                addr_ready,
    output logic                addr_valid,
    output logic [IMG_LOG2-1:0] row,
    output logic [IMG_LOG2-1:0] col,
    output logic [1:0]          pass,
    output logic [1:0]          sweep,
    output logic                blk_first,
    output logic                blk_last,
    output logic                busy,
    output logic                gray_done,
    output logic                compress_done,
    output logic                encode_done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    pass_e      state_q, state_d;
    logic       xfer, launch, blk_mode, at_first, at_blk_last, pass_end;
    logic [1:0] last_sweep;

    assign addr_valid = (state_q != PASS_IDLE);
    assign busy       = addr_valid;
    assign pass       = state_q;
    assign xfer       = addr_valid && addr_ready;
    assign launch     = (state_q == PASS_IDLE) && start;
    assign blk_mode   = (state_q == PASS_CMP) || (state_q == PASS_ENC);
    assign last_sweep = (state_q == PASS_CMP) ? 2'(CMP_SWEEPS - 1) :
                        (state_q == PASS_ENC) ? 2'(ENC_SWEEPS - 1) : 2'd0;
    assign blk_first  = addr_valid && at_first;
    assign blk_last   = addr_valid && at_blk_last;

    blk_scan_counter #(
        .IMG_LOG2 (IMG_LOG2),
        .BLK_LOG2 (BLK_LOG2)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .clear       (launch),
        .advance     (xfer),
        .blk_mode    (blk_mode),
        .last_sweep  (last_sweep),
        .row         (row),
        .col         (col),
        .sweep       (sweep),
        .at_first    (at_first),
        .at_blk_last (at_blk_last),
        .pass_end    (pass_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= PASS_IDLE;
        else     state_q <= state_d;
    end

    // Pass switch happens on the final transfer edge so addr_valid never drops between passes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS_IDLE: if (start)            state_d = PASS_GRAY;
            PASS_GRAY: if (xfer && pass_end) state_d = PASS_CMP;
            PASS_CMP:  if (xfer && pass_end) state_d = PASS_ENC;
            PASS_ENC:  if (xfer && pass_end) state_d = PASS_IDLE;
            default:                         state_d = PASS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            gray_done     <= 1'b0;
            compress_done <= 1'b0;
            encode_done   <= 1'b0;
        end else if (xfer && pass_end) begin
            if (state_q == PASS_GRAY) gray_done     <= 1'b1;
            if (state_q == PASS_CMP)  compress_done <= 1'b1;
            if (state_q == PASS_ENC)  encode_done   <= 1'b1;
        end
    end

`ifdef SEQ_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || launch)                   stall_cnt <= '0;
        else if (addr_valid && !addr_ready)  stall_cnt <= sat_inc(stall_cnt);
    end
`endif

endmodule

// File: tb/tb_img_pass_sequencer.sv
// Directed table-driven bench for img_pass_sequencer with an index-based reference model.
module tb_img_pass_sequencer;

    localparam int NX = 28672;

    logic       clk = 0;
    logic       rst, start, addr_ready;
    logic       addr_valid, blk_first, blk_last, busy;
    logic       gray_done, compress_done, encode_done;
    logic [5:0] row, col;
    logic [1:0] pass, sweep;
`ifdef SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    img_pass_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .addr_ready    (addr_ready),
        .addr_valid    (addr_valid),
        .row           (row),
        .col           (col),
        .pass          (pass),
        .sweep         (sweep),
        .blk_first     (blk_first),
        .blk_last      (blk_last),
        .busy          (busy),
        .gray_done     (gray_done),
        .compress_done (compress_done),
        .encode_done   (encode_done)
`ifdef SEQ_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pass;
        logic [5:0] row;
        logic [5:0] col;
        logic [1:0] sweep;
        logic       first;
        logic       last;
    } xfer_t;

    typedef struct {
        int         idx;
        xfer_t      x;
        logic [2:0] done;
    } vec_t;

    xfer_t      log_x [NX];
    logic [2:0] log_d [NX];
    int         log_c [NX];
    int         n_xfer = 0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    logic       stall_chk = 0;
    logic       prev_stall = 0;
    logic [23:0] prev_snap;
    int         stall_errs = 0;
    int         stall_tb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] snap();
        return {addr_valid, row, col, pass, sweep, blk_first, blk_last, busy,
                gray_done, compress_done, encode_done};
    endfunction

    always @(negedge clk) begin
        if (stall_chk && prev_stall && snap() != prev_snap) stall_errs++;
        prev_snap  = snap();
        prev_stall = addr_valid && !addr_ready;
        if (stall_chk && addr_valid && !addr_ready) stall_tb++;
        if (addr_valid && addr_ready && n_xfer < NX) begin
            log_x[n_xfer] = '{pass, row, col, sweep, blk_first, blk_last};
            log_d[n_xfer] = {encode_done, compress_done, gray_done};
            log_c[n_xfer] = cyc;
            n_xfer++;
        end
    end

    function automatic xfer_t model(input int n);
        xfer_t e;
        int m, per, blk, w, off;
        if (n < 4096) begin
            e.pass = 2'd1; e.row = 6'(n / 64); e.col = 6'(n % 64); e.sweep = 2'd0;
            e.first = (n == 0); e.last = (n == 4095);
        end else begin
            if (n < 20480) begin e.pass = 2'd2; m = n - 4096;  per = 4; end
            else           begin e.pass = 2'd3; m = n - 20480; per = 2; end
            blk = m / (16 * per);
            w   = m % (16 * per);
            off = w % 16;
            e.sweep = 2'(w / 16);
            e.row   = 6'((blk / 16) * 4 + off / 4);
            e.col   = 6'((blk % 16) * 4 + off % 4);
            e.first = (off == 0);
            e.last  = (off == 15) && (w / 16 == per - 1);
        end
        return e;
    endfunction

    function automatic logic [2:0] model_done(input int n);
        return {1'b0, n >= 20480, n >= 4096};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares log entries [0,cnt) against the model; returns first bad index or -1.
    task automatic sweep_log(input int cnt, input logic chk_gap, output int bad_seq,
                             output int bad_done, output int bad_gap);
        bad_seq = -1; bad_done = -1; bad_gap = -1;
        for (int n = 0; n < cnt; n++) begin
            if (bad_seq  < 0 && log_x[n] !== model(n))      bad_seq  = n;
            if (bad_done < 0 && log_d[n] !== model_done(n)) bad_done = n;
            if (chk_gap && bad_gap < 0 && log_c[n] != log_c[0] + n) bad_gap = n;
        end
    endtask

    vec_t tbl [16];
    int   start_cyc, guard, bs, bd, bg;

    initial begin
        tbl[0]  = '{0,     '{2'd1, 6'd0,  6'd0,  2'd0, 1'b1, 1'b0}, 3'b000};
        tbl[1]  = '{1,     '{2'd1, 6'd0,  6'd1,  2'd0, 1'b0, 1'b0}, 3'b000};
        tbl[2]  = '{64,    '{2'd1, 6'd1,  6'd0,  2'd0, 1'b0, 1'b0}, 3'b000};
        tbl[3]  = '{4095,  '{2'd1, 6'd63, 6'd63, 2'd0, 1'b0, 1'b1}, 3'b000};
        tbl[4]  = '{4096,  '{2'd2, 6'd0,  6'd0,  2'd0, 1'b1, 1'b0}, 3'b001};
        tbl[5]  = '{4097,  '{2'd2, 6'd0,  6'd1,  2'd0, 1'b0, 1'b0}, 3'b001};
        tbl[6]  = '{4100,  '{2'd2, 6'd1,  6'd0,  2'd0, 1'b0, 1'b0}, 3'b001};
        tbl[7]  = '{4111,  '{2'd2, 6'd3,  6'd3,  2'd0, 1'b0, 1'b0}, 3'b001};
        tbl[8]  = '{4112,  '{2'd2, 6'd0,  6'd0,  2'd1, 1'b1, 1'b0}, 3'b001};
        tbl[9]  = '{4160,  '{2'd2, 6'd0,  6'd4,  2'd0, 1'b1, 1'b0}, 3'b001};
        tbl[10] = '{5120,  '{2'd2, 6'd4,  6'd0,  2'd0, 1'b1, 1'b0}, 3'b001};
        tbl[11] = '{20479, '{2'd2, 6'd63, 6'd63, 2'd3, 1'b0, 1'b1}, 3'b001};
        tbl[12] = '{20480, '{2'd3, 6'd0,  6'd0,  2'd0, 1'b1, 1'b0}, 3'b011};
        tbl[13] = '{20496, '{2'd3, 6'd0,  6'd0,  2'd1, 1'b1, 1'b0}, 3'b011};
        tbl[14] = '{20512, '{2'd3, 6'd0,  6'd4,  2'd0, 1'b1, 1'b0}, 3'b011};
        tbl[15] = '{28671, '{2'd3, 6'd63, 6'd63, 2'd1, 1'b0, 1'b1}, 3'b011};

        rst = 1; start = 0; addr_ready = 1;
        tick(); tick();
        rst = 0;
        check("reset_outputs", 64'(snap()), 64'd0);

        // Full run with ready=1, stray start pulses mid-GRAY and mid-ENC.
        n_xfer = 0;
        start_cyc = cyc;
        start = 1; tick(); start = 0;
        guard = 0;
        while (n_xfer < NX && guard < 40000) begin
            start = (n_xfer == 100 || n_xfer == 25000);
            tick();
            guard++;
        end
        start = 0;
        check("run1_count", 64'(n_xfer), 64'(NX));
        check("start_latency", 64'(log_c[0]), 64'(start_cyc + 1));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec_%0d_xfer", tbl[i].idx), 64'(log_x[tbl[i].idx]), 64'(tbl[i].x));
            check($sformatf("vec_%0d_done", tbl[i].idx), 64'(log_d[tbl[i].idx]), 64'(tbl[i].done));
        end
        sweep_log(NX, 1'b1, bs, bd, bg);
        check("run1_seq_first_bad", 64'(bs), 64'(-1));
        check("run1_done_first_bad", 64'(bd), 64'(-1));
        check("run1_gap_first_bad", 64'(bg), 64'(-1));
        @(negedge clk);
        check("end_idle", 64'({addr_valid, busy, pass, row, col, sweep}), 64'd0);
        check("end_done_flags", 64'({encode_done, compress_done, gray_done}), 64'b111);

        // Restart after completion, random 50% ready.
        #1;
        n_xfer = 0;
        start = 1; tick(); start = 0;
        check("restart_clears_done", 64'({encode_done, compress_done, gray_done}), 64'd0);
        check("restart_gray_00", 64'({addr_valid, pass, row, col}), 64'({1'b1, 2'd1, 12'd0}));
        stall_chk = 1;
        guard = 0;
        while (n_xfer < 5000 && guard < 20000) begin
            addr_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        addr_ready = 1;
        stall_chk = 0;
        check("run2_count", 64'(n_xfer >= 5000), 64'd1);
        @(negedge clk);
`ifdef SEQ_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_tb));
`endif
        check("stall_hold_errs", 64'(stall_errs), 64'd0);
        check("stall_seen", 64'(stall_tb > 0), 64'd1);
        #1;
        guard = 0;
        while (n_xfer < 6368 && guard < 4000) begin
            tick();
            guard++;
        end
        sweep_log(n_xfer, 1'b0, bs, bd, bg);
        check("run2_seq_first_bad", 64'(bs), 64'(-1));
        check("run2_done_first_bad", 64'(bd), 64'(-1));

        // Abort with reset at CMP block (8,12) sweep 2.
        check("pre_abort_pos", 64'({pass, row, col, sweep}), 64'({2'd2, 6'd8, 6'd12, 2'd2}));
        rst = 1; tick(); rst = 0;
        check("abort_all_zero", 64'(snap()), 64'd0);
        n_xfer = 0;
        start = 1; tick(); start = 0;
        check("rerun_gray_00", 64'({addr_valid, busy, pass, row, col, sweep, blk_first}),
              64'({1'b1, 1'b1, 2'd1, 12'd0, 2'd0, 1'b1}));
        tick(); tick();
        check("rerun_third", 64'({pass, row, col}), 64'({2'd1, 6'd0, 6'd2}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
